add16_seq_arb: RTL and testbench
================================

ADD16_SEQ_ARB -- requirements
Module: add16_seq_arb

Interface
REQ-001 Parameter DW, 16, operand/sum width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 Derived constant NIB, DW/4, number of nibble steps per operation; not overridable.
REQ-003 sys_clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 sys_rst_n  in  1  reset, synchronous, active-low.
REQ-005 req0_valid  in  1  requester 0 has an operation pending.
REQ-006 req0_a, req0_b  in  DW each  requester 0 operands.
REQ-007 req0_cin  in  1  requester 0 carry-in.
REQ-008 req0_ready  out  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-009 req1_valid, req1_a, req1_b, req1_cin, req1_ready: same widths and meanings as requester 0.
REQ-010 rsp_valid  out  1  one-cycle pulse; result fields valid.
REQ-011 rsp_id  out  1  requester that owns the result (0/1).
REQ-012 rsp_sum  out  DW  a+b+cin modulo 2^DW.
REQ-013 rsp_cout  out  1  carry out of bit DW-1.
REQ-014 busy  out  1  high in CALC and DONE.

Function
REQ-015 FSM states SHALL be IDLE, CALC, DONE; reset state IDLE.
REQ-016 In IDLE, the arbiter SHALL assert at most one reqN_ready, only for a requester with reqN_valid high; ready SHALL be 0 in CALC and DONE.
REQ-017 Arbitration SHALL be round-robin: single valid wins; both valid -> the requester not granted last wins; last-grant pointer resets to 1 so req0 wins the first tie.
REQ-018 On acceptance (valid & ready) the block SHALL capture a, b, cin, id into internal registers, clear the nibble index, and move to CALC; later input changes SHALL not affect the result.
REQ-019 In CALC, each cycle SHALL feed nibble k (bits 4k+3..4k) of both operands plus the carry register into the 4-bit adder, store its sum into result nibble k, and store its cout into the carry register; carry register starts at captured cin.
REQ-020 After nibble NIB-1 is processed, the FSM SHALL move to DONE; CALC lasts exactly NIB cycles.
REQ-021 In DONE, rsp_valid SHALL be 1 for exactly one cycle with rsp_id, rsp_sum, rsp_cout; no backpressure; FSM returns to IDLE next cycle.
REQ-022 Latency: acceptance at edge T -> rsp_valid high in the cycle following edge T+NIB+1 (5 edges for DW=16); throughput one op per NIB+2 cycles.
REQ-023 rsp_sum, rsp_cout, rsp_id SHALL hold their last values until the next DONE.
REQ-024 Carry SHALL ripple across nibble boundaries so that all-ones plus cin=1 yields sum 0, cout 1.

Reset
REQ-025 When sys_rst_n is low at a clock edge: state IDLE, nibble index 0, carry 0, last-grant 1, all outputs 0.
REQ-026 Reset during CALC or DONE SHALL abort the operation; no rsp_valid SHALL be produced for it.

Structure
REQ-027 Package add_seq_pkg SHALL hold the state enum, default DW, and the nibble-width constant 4.
REQ-028 Exactly one sub-module: a single Full_adder4 instance (a, b, cin, sum, cout), reused every CALC cycle; no other adder logic.

Verification
REQ-029 req0 a=0x1234 b=0x0FFF cin=0 -> rsp_valid 5 edges after accept, sum=0x2233, cout=0, id=0.
REQ-030 req1 a=0xFFFF b=0x0000 cin=1 -> sum=0x0000, cout=1, id=1.
REQ-031 a=0x8000 b=0x8000 cin=0 -> sum=0x0000, cout=1.
REQ-032 Both valid held continuously from reset -> grants alternate 0,1,0,1; each rsp 6 cycles apart.
REQ-033 sys_rst_n low during the 2nd CALC cycle -> no rsp_valid, busy=0 and outputs 0 after the edge; next req0 op completes correctly.
REQ-034 Operands changed on req0 bus during CALC -> result matches the captured values.

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared types and constants for the nibble-serial adder with two-requester arbitration.
//   state_e    : controller states (IDLE -> CALC -> DONE)
//   DW_DEFAULT : default operand/sum width
//   NIB_W      : width of the reused adder slice
package add_seq_pkg;

  localparam int unsigned DW_DEFAULT = 16;
  localparam int unsigned NIB_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : add_seq_pkg

// File: rtl/add16_seq_arb_full_adder4.sv
// Purpose: 4-bit ripple slice shared across every nibble step of an operation.
// Ports:
//   a, b : 4-bit operand nibbles
//   cin  : carry into bit 0
//   sum  : 4-bit nibble sum
//   cout : carry out of bit 3
module Full_adder4
  import add_seq_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  localparam int unsigned RW = NIB_W + 1;

  logic [RW-1:0] total;

  // Zero-extend before adding so the carry lands in the top bit.
  assign total = RW'(a) + RW'(b) + RW'(cin);
  assign sum   = total[NIB_W-1:0];
  assign cout  = total[NIB_W];

endmodule : Full_adder4

// File: rtl/add16_seq_arb.sv
// Purpose: two requesters share one nibble-serial adder. A round-robin
// arbiter accepts one operation in IDLE, CALC walks the operands one
// nibble per cycle through a single Full_adder4, DONE publishes the result
// as a one-cycle rsp_valid pulse.
// Ports:
//   sys_clk, sys_rst_n          : clock, synchronous active-low reset
//   reqN_valid/a/b/cin          : operation request from requester N
//   reqN_ready                  : acceptance handshake (combinational, IDLE only)
//   rsp_valid                   : one-cycle result pulse
//   rsp_id/rsp_sum/rsp_cout     : owner and result, held until the next result
//   busy                        : operation in flight (CALC or DONE)
module add16_seq_arb
  import add_seq_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic          req0_cin,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic          req1_cin,
  output logic          req1_ready,
  output logic          rsp_valid,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_sum,
  output logic          rsp_cout,
  output logic          busy
);

  localparam int unsigned NIB = DW / NIB_W;
  localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            last_q, last_d;
  logic            id_q, id_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [DW-1:0]   result_q, result_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_id_q, rsp_id_d;
  logic [DW-1:0]   rsp_sum_q, rsp_sum_d;
  logic            rsp_cout_q, rsp_cout_d;
  logic            busy_q, busy_d;

  logic             can_grant;
  logic             gnt0, gnt1;
  logic [NIB_W-1:0] fa_a, fa_b, fa_sum;
  logic             fa_cout;

  // Round-robin: on a tie the requester that did not win last time is granted.
  assign can_grant  = sys_rst_n && (state_q == ST_IDLE);
  assign gnt0       = can_grant && req0_valid && (!req1_valid || last_q);
  assign gnt1       = can_grant && req1_valid && (!req0_valid || !last_q);
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Select the current nibble of each captured operand.
  always_comb begin
    fa_a = '0;
    fa_b = '0;
    for (int unsigned k = 0; k < NIB; k++) begin
      if (idx_q == IW'(k)) begin
        fa_a = a_q[k*NIB_W +: NIB_W];
        fa_b = b_q[k*NIB_W +: NIB_W];
      end
    end
  end

  Full_adder4 u_fa (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    last_d      = last_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt0 || gnt1) begin
          a_d     = gnt1 ? req1_a   : req0_a;
          b_d     = gnt1 ? req1_b   : req0_b;
          carry_d = gnt1 ? req1_cin : req0_cin;
          id_d    = gnt1;
          last_d  = gnt1;
          idx_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        for (int unsigned k = 0; k < NIB; k++) begin
          if (idx_q == IW'(k)) begin
            result_d[k*NIB_W +: NIB_W] = fa_sum;
          end
        end
        carry_d = fa_cout;
        if (idx_q == IW'(NIB - 1)) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = IW'(idx_q + 1'b1);
        end
      end
      ST_DONE: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_sum_d   = result_q;
        rsp_cout_d  = carry_q;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      last_q      <= last_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign busy      = busy_q;

endmodule : add16_seq_arb

// File: tb/tb_add16_seq_arb.sv
// Self-checking bench for add16_seq_arb: directed vectors, round-robin
// arbitration, reset abort, operand isolation and randomized operations
// against an arithmetic reference (a + b + cin).
module tb_add16_seq_arb;

  localparam int unsigned DW  = 16;
  localparam int          LAT = 5;
  localparam int          GAP = 6;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          req0_valid, req0_cin, req0_ready;
  logic [DW-1:0] req0_a, req0_b;
  logic          req1_valid, req1_cin, req1_ready;
  logic [DW-1:0] req1_a, req1_b;
  logic          rsp_valid, rsp_id, rsp_cout, busy;
  logic [DW-1:0] rsp_sum;

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  add16_seq_arb #(.DW(DW)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .busy       (busy)
  );

  // Reference: full-precision addition, top bit is the carry out.
  function automatic logic [DW:0] model_add(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic cin);
    return (DW+1)'(a) + (DW+1)'(b) + (DW+1)'(cin);
  endfunction

  // Issue one operation and wait for its response; reports edges from accept to rsp_valid.
  task automatic do_op(input bit port, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic cin, input bit scramble, output bit ok, output logic id,
                       output logic [DW-1:0] sum, output logic cout, output int lat);
    bit acc;
    ok = 1'b0; id = 1'b0; sum = '0; cout = 1'b0; lat = 0; acc = 1'b0;
    @(negedge sys_clk);
    if (!port) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
    end
    for (int i = 0; i < 20 && !acc; i++) begin
      if ((port ? req1_ready : req0_ready) === 1'b1) acc = 1'b1;
      @(posedge sys_clk);
      if (!acc) @(negedge sys_clk);
    end
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (!acc) return;
    for (int i = 0; i < 20; i++) begin
      @(posedge sys_clk);
      lat++;
      @(negedge sys_clk);
      if (scramble) begin
        req0_a = DW'($urandom); req0_b = DW'($urandom); req0_cin = 1'($urandom);
        req1_a = DW'($urandom); req1_b = DW'($urandom); req1_cin = 1'($urandom);
      end
      if (rsp_valid === 1'b1) begin
        ok = 1'b1; id = rsp_id; sum = rsp_sum; cout = rsp_cout;
        break;
      end
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_sum !== '0) begin failures++; $display("FAIL reset_rsp_sum got=%h exp=0000", rsp_sum); end
    checks++; if (rsp_cout !== 1'b0) begin failures++; $display("FAIL reset_rsp_cout got=%b exp=0", rsp_cout); end
    checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL reset_rsp_id got=%b exp=0", rsp_id); end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin
      failures++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    sys_rst_n = 1'b1;
  endtask

  task automatic test_directed();
    bit            port [3];
    logic [DW-1:0] va [3], vb [3], esum [3];
    logic          vc [3], ecout [3];
    bit ok; logic id, cout; logic [DW-1:0] sum; int lat;
    port[0] = 1'b0; va[0] = 16'h1234; vb[0] = 16'h0FFF; vc[0] = 1'b0; esum[0] = 16'h2233; ecout[0] = 1'b0;
    port[1] = 1'b1; va[1] = 16'hFFFF; vb[1] = 16'h0000; vc[1] = 1'b1; esum[1] = 16'h0000; ecout[1] = 1'b1;
    port[2] = 1'b1; va[2] = 16'h8000; vb[2] = 16'h8000; vc[2] = 1'b0; esum[2] = 16'h0000; ecout[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_op(port[i], va[i], vb[i], vc[i], 1'b0, ok, id, sum, cout, lat);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL dir%0d_response got=%b exp=1", i, ok); end
      checks++; if (sum !== esum[i]) begin failures++; $display("FAIL dir%0d_sum got=%h exp=%h", i, sum, esum[i]); end
      checks++; if (cout !== ecout[i]) begin failures++; $display("FAIL dir%0d_cout got=%b exp=%b", i, cout, ecout[i]); end
      checks++; if (id !== port[i]) begin failures++; $display("FAIL dir%0d_id got=%b exp=%b", i, id, port[i]); end
      checks++; if (lat != LAT) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, LAT); end
      @(negedge sys_clk);
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL dir%0d_pulse_width got=%b exp=0", i, rsp_valid); end
      checks++; if (rsp_sum !== esum[i]) begin failures++; $display("FAIL dir%0d_hold got=%h exp=%h", i, rsp_sum, esum[i]); end
    end
  endtask

  task automatic test_arbitration();
    logic [DW:0] exp0, exp1, exp;
    int cyc, nresp, last_cyc;
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    req0_a = DW'($urandom); req0_b = DW'($urandom); req0_cin = 1'($urandom);
    req1_a = DW'($urandom); req1_b = DW'($urandom); req1_cin = 1'($urandom);
    req0_valid = 1'b1; req1_valid = 1'b1;
    exp0 = model_add(req0_a, req0_b, req0_cin);
    exp1 = model_add(req1_a, req1_b, req1_cin);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    cyc = 0; nresp = 0; last_cyc = 0;
    while (cyc < 100 && nresp < 4) begin
      @(negedge sys_clk);
      cyc++;
      if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
        checks++; failures++; $display("FAIL arb_one_ready got=11 exp=one-hot at cycle %0d", cyc);
      end
      if (busy === 1'b1 && (req0_ready !== 1'b0 || req1_ready !== 1'b0)) begin
        checks++; failures++; $display("FAIL arb_ready_when_busy got=%b%b exp=00", req0_ready, req1_ready);
      end
      if (rsp_valid === 1'b1) begin
        exp = (nresp % 2 == 0) ? exp0 : exp1;
        checks++; if (rsp_id !== 1'((nresp % 2))) begin
          failures++; $display("FAIL arb_grant%0d_id got=%b exp=%0d", nresp, rsp_id, nresp % 2);
        end
        checks++; if ({rsp_cout, rsp_sum} !== exp) begin
          failures++; $display("FAIL arb_grant%0d_result got=%h exp=%h", nresp, {rsp_cout, rsp_sum}, exp);
        end
        if (nresp > 0) begin
          checks++; if (cyc - last_cyc != GAP) begin
            failures++; $display("FAIL arb_spacing%0d got=%0d exp=%0d", nresp, cyc - last_cyc, GAP);
          end
        end
        last_cyc = cyc;
        nresp++;
      end
    end
    checks++; if (nresp != 4) begin failures++; $display("FAIL arb_resp_count got=%0d exp=4", nresp); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic test_reset_abort();
    int stray;
    bit ok; logic id, cout; logic [DW-1:0] sum; int lat;
    logic [DW-1:0] a, b; logic cin; logic [DW:0] exp;
    @(negedge sys_clk);
    req0_valid = 1'b1; req0_a = 16'hABCD; req0_b = 16'h1111; req0_cin = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL abort_accept_ready got=%b exp=1", req0_ready); end
    @(posedge sys_clk);
    #1 req0_valid = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_calc got=%b exp=1", busy); end
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    checks++; if ({busy, rsp_valid, rsp_id, rsp_cout} !== 4'b0000) begin
      failures++; $display("FAIL abort_outputs got=%b exp=0000", {busy, rsp_valid, rsp_id, rsp_cout});
    end
    checks++; if (rsp_sum !== '0) begin failures++; $display("FAIL abort_rsp_sum got=%h exp=0000", rsp_sum); end
    sys_rst_n = 1'b1;
    stray = 0;
    repeat (10) begin
      @(negedge sys_clk);
      if (rsp_valid === 1'b1) stray++;
    end
    checks++; if (stray != 0) begin failures++; $display("FAIL abort_no_rsp got=%0d exp=0", stray); end
    a = DW'($urandom); b = DW'($urandom); cin = 1'($urandom);
    exp = model_add(a, b, cin);
    do_op(1'b0, a, b, cin, 1'b0, ok, id, sum, cout, lat);
    checks++; if (ok !== 1'b1 || {cout, sum} !== exp || id !== 1'b0) begin
      failures++; $display("FAIL abort_recover got=%b/%b/%h exp=1/0/%h", ok, id, {cout, sum}, exp);
    end
  endtask

  task automatic test_operand_change();
    bit ok; logic id, cout; logic [DW-1:0] sum; int lat;
    logic [DW-1:0] a, b; logic cin; logic [DW:0] exp;
    for (int i = 0; i < 3; i++) begin
      a = DW'($urandom); b = DW'($urandom); cin = 1'($urandom);
      exp = model_add(a, b, cin);
      do_op(1'b0, a, b, cin, 1'b1, ok, id, sum, cout, lat);
      checks++; if (ok !== 1'b1 || {cout, sum} !== exp) begin
        failures++; $display("FAIL isolate%0d got=%b/%h exp=1/%h", i, ok, {cout, sum}, exp);
      end
    end
  endtask

  task automatic test_random();
    bit ok; logic id, cout; logic [DW-1:0] sum; int lat;
    bit port; logic [DW-1:0] a, b; logic cin; logic [DW:0] exp;
    for (int i = 0; i < 24; i++) begin
      port = 1'($urandom);
      a = DW'($urandom); b = DW'($urandom); cin = 1'($urandom);
      case ($urandom_range(0, 3))
        0: a = '1;
        1: begin a = '1; b = '0; cin = 1'b1; end
        default: ;
      endcase
      exp = model_add(a, b, cin);
      do_op(port, a, b, cin, 1'b0, ok, id, sum, cout, lat);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rand%0d_response got=%b exp=1", i, ok); end
      checks++; if ({cout, sum} !== exp) begin
        failures++; $display("FAIL rand%0d_result a=%h b=%h cin=%b got=%h exp=%h", i, a, b, cin, {cout, sum}, exp);
      end
      checks++; if (id !== port) begin failures++; $display("FAIL rand%0d_id got=%b exp=%b", i, id, port); end
      checks++; if (lat != LAT) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=%0d", i, lat, LAT); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_arbitration();
    test_reset_abort();
    test_operand_change();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_add16_seq_arb
